biriscv_branch_arb: RTL and testbench



---
 rtl/biriscv_branch_arb_pkg.sv | 19 +
 rtl/biriscv_branch_fifo.sv | 63 ++++++
 rtl/biriscv_branch_arb.sv | 96 +++++++++
 tb/tb_biriscv_branch_arb.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/biriscv_branch_arb_pkg.sv
// Shared branch-record types and branch-kind encodings used by the exec units,
// the branch arbiter and the next-PC predictor.
package biriscv_branch_arb_pkg;

  localparam logic [1:0] BR_TYPE_COND = 2'b00;
  localparam logic [1:0] BR_TYPE_CALL = 2'b01;
  localparam logic [1:0] BR_TYPE_RET  = 2'b10;
  localparam logic [1:0] BR_TYPE_JMP  = 2'b11;

  typedef struct packed {
    logic        taken;
    logic [31:0] source;
    logic [31:0] pc;
    logic [1:0]  kind;
  } br_rec_t;

  localparam int unsigned BR_REC_W = $bits(br_rec_t);

endpackage

// File: rtl/biriscv_branch_fifo.sv
// Dual-push, single-pop circular buffer. Push 0 is older and lands closer to the head;
// pushes are accepted in age order while space (including a same-cycle pop) remains.
module biriscv_branch_fifo #(
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned WIDTH  = 67,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push0_i,
  input  logic [WIDTH-1:0]  data0_i,
  input  logic              push1_i,
  input  logic [WIDTH-1:0]  data1_i,
  input  logic              pop_i,
  output logic              acc0_o,
  output logic              acc1_o,
  output logic [WIDTH-1:0]  head_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic [ADDR_W:0]   count_next_o
);

  localparam logic [ADDR_W+1:0] DepthW = (ADDR_W + 2)'(DEPTH);
  localparam logic [ADDR_W+1:0] One    = (ADDR_W + 2)'(1);
  localparam logic [ADDR_W+1:0] Two    = (ADDR_W + 2)'(2);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d, wr1_ptr;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W+1:0] space;
  logic [1:0]        n_acc;

  always_comb begin
    space   = DepthW - {1'b0, count_q} + {{(ADDR_W + 1){1'b0}}, pop_i};
    acc0_o  = push0_i && (space >= One);
    acc1_o  = push1_i && (acc0_o ? (space >= Two) : (space >= One));
    n_acc   = {1'b0, acc0_o} + {1'b0, acc1_o};
    wr1_ptr = acc0_o ? tail_q + ADDR_W'(1) : tail_q;
    tail_d  = tail_q + ADDR_W'(n_acc);
    head_d  = head_q + ADDR_W'(pop_i);
    count_d = count_q + (ADDR_W + 1)'(n_acc) - (ADDR_W + 1)'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (acc0_o) mem_q[tail_q]  <= data0_i;
      if (acc1_o) mem_q[wr1_ptr] <= data1_i;
    end
  end

  // When empty, show the most recently popped slot so the output holds its last value.
  assign head_data_o  = (count_q == '0) ? mem_q[head_q - ADDR_W'(1)] : mem_q[head_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/biriscv_branch_arb.sv
// Branch resolution arbiter: qualifies the two exec-pipe branch records, buffers the
// survivors in age order and drains them to the next-PC predictor.
module biriscv_branch_arb
  import biriscv_branch_arb_pkg::*;
#(
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              br0_valid_i,
  input  logic              br0_taken_i,
  input  logic [31:0]       br0_source_i,
  input  logic [31:0]       br0_pc_i,
  input  logic [1:0]        br0_type_i,
  input  logic              br1_valid_i,
  input  logic              br1_taken_i,
  input  logic [31:0]       br1_source_i,
  input  logic [31:0]       br1_pc_i,
  input  logic [1:0]        br1_type_i,
  output logic              upd_valid_o,
  input  logic              upd_ready_i,
  output logic              upd_taken_o,
  output logic [31:0]       upd_source_o,
  output logic [31:0]       upd_pc_o,
  output logic [1:0]        upd_type_o,
  output logic              hold_o,
  output logic              squash_o,
  output logic              overflow_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W:0] HoldThr = (ADDR_W + 1)'(DEPTH - 2);

  logic            kill, push0, push1, pop, acc0, acc1;
  logic            hold_q, hold_d, squash_q, squash_d, overflow_q, overflow_d;
  logic [ADDR_W:0] count_next;
  br_rec_t         rec0, rec1, head;

  always_comb begin
    kill  = br0_valid_i & br0_taken_i;
    push0 = br0_valid_i & ~flush_i;
    push1 = br1_valid_i & ~kill & ~flush_i;
    pop   = upd_valid_o & upd_ready_i;
    rec0  = '{taken: br0_taken_i, source: br0_source_i, pc: br0_pc_i, kind: br0_type_i};
    rec1  = '{taken: br1_taken_i, source: br1_source_i, pc: br1_pc_i, kind: br1_type_i};
  end

  biriscv_branch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BR_REC_W)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push0_i      (push0),
    .data0_i      (rec0),
    .push1_i      (push1),
    .data1_i      (rec1),
    .pop_i        (pop),
    .acc0_o       (acc0),
    .acc1_o       (acc1),
    .head_data_o  (head),
    .count_o      (count_o),
    .count_next_o (count_next)
  );

  always_comb begin
    squash_d   = br1_valid_i & kill & ~flush_i;
    overflow_d = overflow_q | (push0 & ~acc0) | (push1 & ~acc1);
    // Fewer than two free slots after this edge means a dual push might not fit.
    hold_d     = count_next > HoldThr;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q     <= 1'b0;
      squash_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      squash_q   <= squash_d;
      overflow_q <= overflow_d;
    end
  end

  assign upd_valid_o  = count_o != '0;
  assign upd_taken_o  = head.taken;
  assign upd_source_o = head.source;
  assign upd_pc_o     = head.pc;
  assign upd_type_o   = head.kind;
  assign hold_o       = hold_q;
  assign squash_o     = squash_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_biriscv_branch_arb.sv
// Directed bench for biriscv_branch_arb at DEPTH = 4: a vector table plus hand-written
// reset-mid-stream and wrap-around sequences with a small in-order scoreboard.
module tb_biriscv_branch_arb;
  import biriscv_branch_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        br0_valid_i, br0_taken_i, br1_valid_i, br1_taken_i;
  logic [31:0] br0_source_i, br0_pc_i, br1_source_i, br1_pc_i;
  logic [1:0]  br0_type_i, br1_type_i;
  logic        upd_valid_o, upd_ready_i, upd_taken_o;
  logic [31:0] upd_source_o, upd_pc_o;
  logic [1:0]  upd_type_o;
  logic        hold_o, squash_o, overflow_o;
  logic [2:0]  count_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  biriscv_branch_arb #(.DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .br0_valid_i  (br0_valid_i),
    .br0_taken_i  (br0_taken_i),
    .br0_source_i (br0_source_i),
    .br0_pc_i     (br0_pc_i),
    .br0_type_i   (br0_type_i),
    .br1_valid_i  (br1_valid_i),
    .br1_taken_i  (br1_taken_i),
    .br1_source_i (br1_source_i),
    .br1_pc_i     (br1_pc_i),
    .br1_type_i   (br1_type_i),
    .upd_valid_o  (upd_valid_o),
    .upd_ready_i  (upd_ready_i),
    .upd_taken_o  (upd_taken_o),
    .upd_source_o (upd_source_o),
    .upd_pc_o     (upd_pc_o),
    .upd_type_o   (upd_type_o),
    .hold_o       (hold_o),
    .squash_o     (squash_o),
    .overflow_o   (overflow_o),
    .count_o      (count_o)
  );

  typedef struct {
    logic fl, v0, t0; logic [31:0] s0; logic [1:0] ty0;
    logic v1, t1; logic [31:0] s1; logic [1:0] ty1; logic rdy;
    logic ev, et; logic [31:0] es; logic [1:0] ety; logic eh, esq, eov; logic [2:0] ecnt;
  } vec_t;

  localparam int NVec = 20;
  vec_t tbl[NVec];

  function automatic logic [31:0] pc_of(input logic [31:0] src);
    return src + 32'h100;
  endfunction

  function automatic vec_t mk(
    input logic fl, v0, t0, input logic [31:0] s0, input logic [1:0] ty0,
    input logic v1, t1, input logic [31:0] s1, input logic [1:0] ty1, input logic rdy,
    input logic ev, et, input logic [31:0] es, input logic [1:0] ety,
    input logic eh, esq, eov, input logic [2:0] ecnt);
    vec_t v;
    v.fl = fl; v.v0 = v0; v.t0 = t0; v.s0 = s0; v.ty0 = ty0;
    v.v1 = v1; v.t1 = t1; v.s1 = s1; v.ty1 = ty1; v.rdy = rdy;
    v.ev = ev; v.et = et; v.es = es; v.ety = ety;
    v.eh = eh; v.esq = esq; v.eov = eov; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush_i = 0; br0_valid_i = 0; br0_taken_i = 0; br0_source_i = 0; br0_pc_i = 0;
    br0_type_i = 0; br1_valid_i = 0; br1_taken_i = 0; br1_source_i = 0; br1_pc_i = 0;
    br1_type_i = 0; upd_ready_i = 0;
  endtask

  task automatic drive0(input logic t, input logic [31:0] s, input logic [1:0] ty);
    br0_valid_i = 1; br0_taken_i = t; br0_source_i = s; br0_pc_i = pc_of(s); br0_type_i = ty;
  endtask

  task automatic drive1(input logic t, input logic [31:0] s, input logic [1:0] ty);
    br1_valid_i = 1; br1_taken_i = t; br1_source_i = s; br1_pc_i = pc_of(s); br1_type_i = ty;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, "_count"}, 64'(count_o), 0);
    chk({tag, "_valid"}, 64'(upd_valid_o), 0);
    chk({tag, "_hold"}, 64'(hold_o), 0);
    chk({tag, "_squash"}, 64'(squash_o), 0);
    chk({tag, "_overflow"}, 64'(overflow_o), 0);
  endtask

  initial begin
    int sent, got;
    string n;
    localparam logic [1:0] C = BR_TYPE_COND, L = BR_TYPE_CALL, R = BR_TYPE_RET, J = BR_TYPE_JMP;

    // fl v0 t0 s0 ty0 | v1 t1 s1 ty1 | rdy || ev et es ety | hold squash ovf count
    tbl[0]  = mk(0, 1, 1, 'h100, J, 0, 0, 0, C, 1,   1, 1, 'h100, J, 0, 0, 0, 1);
    tbl[1]  = mk(0, 0, 0, 0, C, 0, 0, 0, C, 1,       0, 1, 'h100, J, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 'h10, C, 1, 1, 'h14, L, 0, 1, 0, 'h10, C, 0, 0, 0, 2);
    tbl[3]  = mk(0, 0, 0, 0, C, 0, 0, 0, C, 1,       1, 1, 'h14, L, 0, 0, 0, 1);
    tbl[4]  = mk(0, 1, 0, 'h20, C, 0, 0, 0, C, 0,    1, 1, 'h14, L, 0, 0, 0, 2);
    tbl[5]  = mk(0, 1, 0, 'h24, R, 0, 0, 0, C, 0,    1, 1, 'h14, L, 1, 0, 0, 3);
    tbl[6]  = mk(0, 0, 0, 0, C, 0, 0, 0, C, 1,       1, 0, 'h20, C, 0, 0, 0, 2);
    tbl[7]  = mk(0, 0, 0, 0, C, 0, 0, 0, C, 1,       1, 0, 'h24, R, 0, 0, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0, C, 0, 0, 0, C, 1,       0, 0, 'h24, R, 0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 1, 'h30, L, 1, 0, 'h34, C, 0, 1, 1, 'h30, L, 0, 1, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, C, 0, 0, 0, C, 0,       1, 1, 'h30, L, 0, 0, 0, 1);
    tbl[11] = mk(1, 1, 1, 'h38, C, 1, 0, 'h3c, C, 0, 1, 1, 'h30, L, 0, 0, 0, 1);
    tbl[12] = mk(0, 1, 0, 'h40, C, 1, 0, 'h44, R, 0, 1, 1, 'h30, L, 1, 0, 0, 3);
    tbl[13] = mk(0, 1, 0, 'h48, L, 0, 0, 0, C, 0,    1, 1, 'h30, L, 1, 0, 0, 4);
    tbl[14] = mk(0, 1, 0, 'h50, C, 1, 0, 'h54, C, 0, 1, 1, 'h30, L, 1, 0, 1, 4);
    tbl[15] = mk(0, 1, 0, 'h58, J, 1, 0, 'h5c, C, 1, 1, 0, 'h40, C, 1, 0, 1, 4);
    tbl[16] = mk(0, 0, 0, 0, C, 0, 0, 0, C, 1,       1, 0, 'h44, R, 1, 0, 1, 3);
    tbl[17] = mk(0, 0, 0, 0, C, 0, 0, 0, C, 1,       1, 0, 'h48, L, 0, 0, 1, 2);
    tbl[18] = mk(0, 0, 0, 0, C, 0, 0, 0, C, 1,       1, 0, 'h58, J, 0, 0, 1, 1);
    tbl[19] = mk(0, 0, 0, 0, C, 0, 0, 0, C, 1,       0, 0, 'h58, J, 0, 0, 1, 0);

    idle_inputs();
    rst_ni = 0;
    step();
    step();
    chk_idle_state("reset");
    chk("reset_source", 64'(upd_source_o), 0);
    #2 rst_ni = 1;
    step();

    for (int i = 0; i < NVec; i++) begin
      idle_inputs();
      flush_i = tbl[i].fl;
      upd_ready_i = tbl[i].rdy;
      if (tbl[i].v0) drive0(tbl[i].t0, tbl[i].s0, tbl[i].ty0);
      if (tbl[i].v1) drive1(tbl[i].t1, tbl[i].s1, tbl[i].ty1);
      step();
      n = $sformatf("vec%0d", i);
      chk({n, "_valid"}, 64'(upd_valid_o), 64'(tbl[i].ev));
      chk({n, "_taken"}, 64'(upd_taken_o), 64'(tbl[i].et));
      chk({n, "_source"}, 64'(upd_source_o), 64'(tbl[i].es));
      chk({n, "_pc"}, 64'(upd_pc_o), 64'(pc_of(tbl[i].es)));
      chk({n, "_type"}, 64'(upd_type_o), 64'(tbl[i].ety));
      chk({n, "_hold"}, 64'(hold_o), 64'(tbl[i].eh));
      chk({n, "_squash"}, 64'(squash_o), 64'(tbl[i].esq));
      chk({n, "_overflow"}, 64'(overflow_o), 64'(tbl[i].eov));
      chk({n, "_count"}, 64'(count_o), 64'(tbl[i].ecnt));
    end

    // Reset mid-stream with three entries buffered and overflow still set.
    idle_inputs();
    drive0(0, 'h60, C);
    drive1(0, 'h64, C);
    step();
    idle_inputs();
    drive0(0, 'h68, C);
    step();
    idle_inputs();
    chk("pre_rst_count", 64'(count_o), 3);
    chk("pre_rst_hold", 64'(hold_o), 1);
    #2 rst_ni = 0;
    #1;
    chk_idle_state("mid_rst");
    step();
    #2 rst_ni = 1;
    step();
    chk_idle_state("post_rst");

    // Wrap-around: ten records, ready toggling, pushes gated by hold_o.
    sent = 0;
    got  = 0;
    for (int k = 0; k < 200 && got < 10; k++) begin
      idle_inputs();
      upd_ready_i = (k % 3) != 0;
      if (!hold_o && sent < 10) begin
        drive0(0, 32'h1000 + 32'(4 * sent), BR_TYPE_COND);
        sent++;
        if (k % 2 == 0 && sent < 10) begin
          drive1(0, 32'h1000 + 32'(4 * sent), BR_TYPE_CALL);
          sent++;
        end
      end
      if (upd_valid_o && upd_ready_i) begin
        chk($sformatf("wrap%0d_source", got), 64'(upd_source_o), 64'(32'h1000 + 32'(4 * got)));
        chk($sformatf("wrap%0d_pc", got), 64'(upd_pc_o), 64'(pc_of(32'h1000 + 32'(4 * got))));
        got++;
      end
      step();
    end
    chk("wrap_popped", 64'(got), 10);
    chk("wrap_overflow", 64'(overflow_o), 0);
    chk("wrap_count", 64'(count_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
